// File: rtl/tt_um_seq_mult_if.sv
// Operand/result handshake bundle for the sequential multiplier.
// The master drives operands and consumes the product; the slave is the multiplier.
interface tt_um_seq_mult_if #(
    parameter int WIDTH = 4
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 signed_mode;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   product;

    modport master (
        output in_valid, a, b, signed_mode, out_ready,
        input  in_ready, out_valid, product
    );

    modport slave (
        input  in_valid, a, b, signed_mode, out_ready,
        output in_ready, out_valid, product
    );
endinterface

// File: rtl/tt_um_seq_mult.sv
// Sequential shift-add multiplier, one multiplier bit per clock, with a sign-magnitude
// wrapper for two's-complement operands and valid/ready handshakes on both sides.
module tt_um_seq_mult #(
    parameter int WIDTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    tt_um_seq_mult_if.slave   bus
);
    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   mcand_q;
    logic [WIDTH-1:0] mplier_q;
    logic [PW-1:0]   acc_q;
    logic            neg_q;
    logic [CW-1:0]   cnt_q;
    logic [PW-1:0]   product_q;

    logic [WIDTH-1:0] a_mag, b_mag;
    logic             neg_d;
    logic [PW-1:0]    acc_step;
    logic [PW-1:0]    prod_fix;
    logic             accept;
    logic             step;

    // |-2^(W-1)| wraps to 2^(W-1), which is exactly right read as unsigned.
    always_comb begin
        a_mag = (bus.signed_mode && bus.a[WIDTH-1]) ? -bus.a : bus.a;
        b_mag = (bus.signed_mode && bus.b[WIDTH-1]) ? -bus.b : bus.b;
        neg_d = bus.signed_mode & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
    end

    always_comb begin
        acc_step = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
        prod_fix = neg_q ? -acc_q : acc_q;
    end

    assign accept = (state_q == S_IDLE) && bus.in_valid;
    assign step   = (state_q == S_RUN) && (cnt_q != '0);

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (bus.in_valid)  state_d = S_RUN;
            S_RUN:   if (cnt_q == '0)   state_d = S_DONE;
            S_DONE:  if (bus.out_ready) state_d = S_IDLE;
            default:                    state_d = S_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        unique case (state_q)
            S_IDLE:  bus.in_ready  = 1'b1;
            S_DONE:  bus.out_valid = 1'b1;
            default: ;
        endcase
    end

    // Datapath: the RUN cycle with cnt_q==0 is the sign-fix/load into DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            neg_q     <= 1'b0;
            cnt_q     <= '0;
            product_q <= '0;
        end else if (accept) begin
            mcand_q   <= PW'(a_mag);
            mplier_q  <= b_mag;
            acc_q     <= '0;
            neg_q     <= neg_d;
            cnt_q     <= CW'(WIDTH);
        end else if (step) begin
            acc_q     <= acc_step;
            mcand_q   <= mcand_q << 1;
            mplier_q  <= mplier_q >> 1;
            cnt_q     <= cnt_q - 1'b1;
        end else if (state_q == S_RUN) begin
            product_q <= prod_fix;
        end
    end

    assign bus.product = product_q;

endmodule

// File: tb/tb_tt_um_seq_mult.sv
// Directed and randomized checks of the sequential multiplier at WIDTH=4 and WIDTH=8
// against an arithmetic reference product.
module tb_tt_um_seq_mult;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    tt_um_seq_mult_if #(.WIDTH(4)) b4 ();
    tt_um_seq_mult_if #(.WIDTH(8)) b8 ();

    tt_um_seq_mult #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(b4));
    tt_um_seq_mult #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(b8));

    int vecs = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: interpret operands as integers, multiply, keep 2*w low bits.
    function automatic logic [15:0] ref_mul(input int w, input logic [7:0] a,
                                            input logic [7:0] b, input bit sm);
        longint m, av, bv, p;
        m  = (longint'(1) << w) - 1;
        av = longint'(a) & m;
        bv = longint'(b) & m;
        if (sm) begin
            if (av > (m >> 1)) av = av - (m + 1);
            if (bv > (m >> 1)) bv = bv - (m + 1);
        end
        p = (av * bv) & ((longint'(1) << (2 * w)) - 1);
        return p[15:0];
    endfunction

    task automatic start4(input logic [3:0] a, input logic [3:0] b, input bit sm);
        @(negedge clk);
        chk("w4_in_ready_idle", 32'(b4.in_ready), 32'd1);
        b4.a = a; b4.b = b; b4.signed_mode = sm; b4.in_valid = 1'b1;
        @(negedge clk);
        b4.in_valid = 1'b0;
    endtask

    task automatic wait4(input int lat0, output int lat);
        lat = lat0;
        while (b4.out_valid !== 1'b1 && lat < 50) begin
            chk("w4_in_ready_busy", 32'(b4.in_ready), 32'd0);
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic finish4(input string tag, input int lat, input logic [7:0] exp, input int hold);
        chk({tag, "_latency"}, 32'(lat), 32'd5);
        chk({tag, "_product"}, 32'(b4.product), 32'(exp));
        chk({tag, "_in_ready_done"}, 32'(b4.in_ready), 32'd0);
        repeat (hold) begin
            @(negedge clk);
            chk({tag, "_hold_valid"}, 32'(b4.out_valid), 32'd1);
            chk({tag, "_hold_product"}, 32'(b4.product), 32'(exp));
            chk({tag, "_hold_in_ready"}, 32'(b4.in_ready), 32'd0);
        end
        b4.out_ready = 1'b1;
        @(negedge clk);
        b4.out_ready = 1'b0;
        chk({tag, "_retire_valid"}, 32'(b4.out_valid), 32'd0);
        chk({tag, "_retire_in_ready"}, 32'(b4.in_ready), 32'd1);
    endtask

    task automatic op4(input string tag, input logic [3:0] a, input logic [3:0] b,
                       input bit sm, input int hold);
        int lat;
        start4(a, b, sm);
        wait4(0, lat);
        finish4(tag, lat, ref_mul(4, 8'(a), 8'(b), sm)[7:0], hold);
    endtask

    initial begin
        int lat;
        logic [7:0] ra, rb;
        bit rs;
        logic [15:0] e16;
        rst_n = 1'b0;
        b4.in_valid = 0; b4.a = '0; b4.b = '0; b4.signed_mode = 0; b4.out_ready = 0;
        b8.in_valid = 0; b8.a = '0; b8.b = '0; b8.signed_mode = 0; b8.out_ready = 0;
        #12;
        chk("rst_in_ready", 32'(b4.in_ready), 32'd1);
        chk("rst_out_valid", 32'(b4.out_valid), 32'd0);
        chk("rst_product", 32'(b4.product), 32'd0);
        chk("rst_product_w8", 32'(b8.product), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Fixed corner cases
        op4("u15x15", 4'hF, 4'hF, 1'b0, 0);
        chk("ref_u15x15", 32'(ref_mul(4, 8'hF, 8'hF, 1'b0)), 32'hE1);
        op4("s_m8xm8", 4'h8, 4'h8, 1'b1, 0);
        op4("s_m8x7", 4'h8, 4'h7, 1'b1, 0);
        op4("u8x8", 4'h8, 4'h8, 1'b0, 0);
        op4("u0x9", 4'h0, 4'h9, 1'b0, 0);
        op4("s0xm3", 4'h0, 4'hD, 1'b1, 0);
        op4("s_m1x1", 4'hF, 4'h1, 1'b1, 0);

        // Backpressure: hold 10 cycles in DONE
        op4("bp", 4'h9, 4'h6, 1'b1, 10);

        // New operands during RUN must be ignored
        start4(4'h6, 4'h7, 1'b0);
        b4.a = 4'hF; b4.b = 4'hF; b4.signed_mode = 1'b1; b4.in_valid = 1'b1;
        @(negedge clk);
        @(negedge clk);
        b4.in_valid = 1'b0;
        wait4(2, lat);
        finish4("ign", lat, 8'h2A, 0);

        // Reset in the middle of RUN
        start4(4'h3, 4'h3, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(b4.out_valid), 32'd0);
        chk("midrst_product", 32'(b4.product), 32'd0);
        chk("midrst_in_ready", 32'(b4.in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            chk("midrst_no_pulse", 32'(b4.out_valid), 32'd0);
        end
        op4("post_rst_3x5", 4'h3, 4'h5, 1'b0, 0);

        // WIDTH=8 random sweep with out_ready held high
        b8.out_ready = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rs = 1'($urandom);
            if (i == 0) begin ra = 8'h80; rb = 8'h80; rs = 1'b1; end
            if (i == 1) begin ra = 8'h00; rb = 8'hC3; rs = 1'b1; end
            if (i == 2) begin ra = 8'hFF; rb = 8'hFF; rs = 1'b0; end
            e16 = ref_mul(8, ra, rb, rs);
            @(negedge clk);
            chk("w8_in_ready", 32'(b8.in_ready), 32'd1);
            b8.a = ra; b8.b = rb; b8.signed_mode = rs; b8.in_valid = 1'b1;
            @(negedge clk);
            b8.in_valid = 1'b0;
            lat = 0;
            while (b8.out_valid !== 1'b1 && lat < 50) begin
                @(negedge clk);
                lat++;
            end
            chk("w8_latency", 32'(lat), 32'd9);
            chk("w8_product", 32'(b8.product), 32'(e16));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
        $finish;
    end
endmodule
